calc_key_sequencer: RTL

// - Upstream stage of the calculator memory block: turns raw keypad presses into its strobes.
// - Strobes driven: num, operator, save_enable, op_enable, equ_enable, clear_enable.
// - Synchronizes and debounces the key-valid line, then runs an entry FSM: operand A, operator, operand B, '=', result.
// - Emits one registered single-cycle command per accepted key.

---
 rtl/calc_pkg.sv | 46 ++++
 rtl/calc_key_sequencer_key_debounce.sv | 61 ++++++
 rtl/calc_key_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// ============================================================================
// Module : calc_pkg
// Shared key codes, save_enable encodings and entry-FSM state codes for the
// calculator key sequencer, memory block and their benches.
// Revision: 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQU = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [1:0] SAVE_NONE = 2'b00;
  localparam logic [1:0] SAVE_A    = 2'b01;
  localparam logic [1:0] SAVE_OP   = 2'b10;
  localparam logic [1:0] SAVE_B    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPND_A = 3'd1,
    ST_OP_SEL = 3'd2,
    ST_OPND_B = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  function automatic logic is_digit(logic [3:0] code);
    return code <= 4'd9;
  endfunction

  function automatic logic is_oper(logic [3:0] code);
    return (code >= KEY_ADD) && (code <= KEY_DIV);
  endfunction

  // Operator index is key_code-10; modulo 4 this is the low two bits plus 2.
  function automatic logic [1:0] oper_of(logic [1:0] code_lo);
    return code_lo + 2'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_key_sequencer_key_debounce.sv
// ============================================================================
// Module : key_debounce
// Two-flop synchronizer, stability counter and single-cycle press detector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic press_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level differs from the accepted one,
  // so any bounce back to the accepted level restarts it from zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_evt = press_q;

endmodule

`default_nettype wire

// File: rtl/calc_key_sequencer.sv
// ============================================================================
// Module : calc_key_sequencer
// Keypad entry FSM: turns debounced key presses into registered memory strobes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] num,
  output logic [1:0] operator,
  output logic [1:0] save_enable,
  output logic       op_enable,
  output logic       equ_enable,
  output logic       clear_enable,
  output logic [2:0] state_o
);

  localparam int DCW = $clog2(MAX_DIGITS + 1);
  localparam logic [DCW-1:0] DIG_MAX = DCW'(MAX_DIGITS);

  logic press_evt;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (key_valid),
    .press_evt (press_evt)
  );

  state_t           state_q, state_d;
  logic [DCW-1:0]   cnt_a_q, cnt_a_d;
  logic [DCW-1:0]   cnt_b_q, cnt_b_d;
  logic             pend_q, pend_d;
  logic [3:0]       pend_dig_q, pend_dig_d;
  logic [3:0]       num_q, num_d;
  logic [1:0]       oper_q, oper_d;
  logic [1:0]       save_q, save_d;
  logic             op_en_q, op_en_d;
  logic             equ_q, equ_d;
  logic             clr_q, clr_d;

  logic w_clr, w_dig, w_op, w_equ;
  assign w_clr = press_evt && (key_code == KEY_CLR);
  assign w_dig = press_evt && is_digit(key_code);
  assign w_op  = press_evt && is_oper(key_code);
  assign w_equ = press_evt && (key_code == KEY_EQU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      pend_q     <= 1'b0;
      pend_dig_q <= '0;
      num_q      <= '0;
      oper_q     <= '0;
      save_q     <= SAVE_NONE;
      op_en_q    <= 1'b0;
      equ_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      pend_q     <= pend_d;
      pend_dig_q <= pend_dig_d;
      num_q      <= num_d;
      oper_q     <= oper_d;
      save_q     <= save_d;
      op_en_q    <= op_en_d;
      equ_q      <= equ_d;
      clr_q      <= clr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    pend_d     = 1'b0;
    pend_dig_d = pend_dig_q;
    if (w_clr) begin
      state_d = ST_IDLE;
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else if (!pend_q) begin
      case (state_q)
        ST_IDLE, ST_OPND_A: begin
          if (w_dig && (cnt_a_q < DIG_MAX)) begin
            state_d = ST_OPND_A;
            cnt_a_d = cnt_a_q + 1'b1;
          end else if (w_op && (state_q == ST_OPND_A)) begin
            state_d = ST_OP_SEL;
          end
        end
        ST_OP_SEL, ST_OPND_B: begin
          if (w_dig && (cnt_b_q < DIG_MAX)) begin
            state_d = ST_OPND_B;
            cnt_b_d = cnt_b_q + 1'b1;
          end else if (w_equ && (state_q == ST_OPND_B)) begin
            state_d = ST_RESULT;
          end
        end
        ST_RESULT: begin
          // A digit starts a fresh calculation: clear first, save next cycle.
          if (w_dig) begin
            state_d    = ST_OPND_A;
            cnt_a_d    = DCW'(1);
            cnt_b_d    = '0;
            pend_d     = 1'b1;
            pend_dig_d = key_code;
          end else if (w_op) begin
            state_d = ST_OP_SEL;
            cnt_b_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    save_d  = SAVE_NONE;
    op_en_d = 1'b0;
    equ_d   = 1'b0;
    clr_d   = 1'b0;
    num_d   = num_q;
    oper_d  = oper_q;
    if (w_clr) begin
      clr_d = 1'b1;
    end else if (pend_q) begin
      save_d = SAVE_A;
      num_d  = pend_dig_q;
    end else begin
      case (state_q)
        ST_IDLE, ST_OPND_A: begin
          if (w_dig && (cnt_a_q < DIG_MAX)) begin
            save_d = SAVE_A;
            num_d  = key_code;
          end else if (w_op && (state_q == ST_OPND_A)) begin
            save_d  = SAVE_OP;
            op_en_d = 1'b1;
            oper_d  = oper_of(key_code[1:0]);
          end
        end
        ST_OP_SEL, ST_OPND_B: begin
          if (w_dig && (cnt_b_q < DIG_MAX)) begin
            save_d = SAVE_B;
            num_d  = key_code;
          end else if (w_op && (state_q == ST_OP_SEL)) begin
            save_d  = SAVE_OP;
            op_en_d = 1'b1;
            oper_d  = oper_of(key_code[1:0]);
          end else if (w_equ && (state_q == ST_OPND_B)) begin
            equ_d = 1'b1;
          end
        end
        ST_RESULT: begin
          if (w_dig) begin
            clr_d = 1'b1;
          end else if (w_op) begin
            save_d  = SAVE_OP;
            op_en_d = 1'b1;
            oper_d  = oper_of(key_code[1:0]);
          end
        end
        default: ;
      endcase
    end
  end

  assign num          = num_q;
  assign operator     = oper_q;
  assign save_enable  = save_q;
  assign op_enable    = op_en_q;
  assign equ_enable   = equ_q;
  assign clear_enable = clr_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire
